// File: rtl/expe_cmd_rx.sv
// Command frame receiver: parses AA/CODE/CHK byte frames and updates the experiment select register.
// Bad frames and inter-byte timeouts are reported on err/err_code.
module expe_cmd_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] select,
  output logic       sel_update,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      HDR      = 8'hAA;

  typedef enum logic [1:0] {IDLE, GET_CODE, GET_SUM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       code_q;
  logic             tmo;
  logic             accept, reject;
  logic [1:0]       rej_code;

  // Legal select codes: 00, 11-15, 21-29, 31-36, 41-46.
  function automatic logic code_valid(input logic [7:0] c);
    logic [3:0] lo;
    lo = c[3:0];
    case (c[7:4])
      4'h0:    return (lo == 4'h0);
      4'h1:    return (lo >= 4'h1) && (lo <= 4'h5);
      4'h2:    return (lo >= 4'h1) && (lo <= 4'h9);
      4'h3:    return (lo >= 4'h1) && (lo <= 4'h6);
      4'h4:    return (lo >= 4'h1) && (lo <= 4'h6);
      default: return 1'b0;
    endcase
  endfunction

  // A byte in the last allowed cycle beats the timeout.
  assign tmo = (state_q != IDLE) && !rx_valid && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_valid && rx_data == HDR) state_d = GET_CODE;
      GET_CODE: if (rx_valid)                   state_d = GET_SUM;
                else if (tmo)                   state_d = IDLE;
      GET_SUM:  if (rx_valid || tmo)            state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Checksum is judged before code legality.
  always_comb begin
    accept   = 1'b0;
    reject   = 1'b0;
    rej_code = 2'b00;
    busy     = (state_q != IDLE);
    if (state_q == GET_SUM && rx_valid) begin
      if (rx_data != (HDR ^ code_q)) begin
        reject   = 1'b1;
        rej_code = 2'b10;
      end else if (!code_valid(code_q)) begin
        reject   = 1'b1;
        rej_code = 2'b01;
      end else begin
        accept = 1'b1;
      end
    end else if (tmo) begin
      reject   = 1'b1;
      rej_code = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                cnt_q <= '0;
    else if (rx_valid || state_d == IDLE)   cnt_q <= '0;
    else if (cnt_q != CNT_LAST)             cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state_q == GET_CODE && rx_valid) code_q <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      select     <= 8'h00;
      sel_update <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      sel_update <= accept;
      err        <= reject;
      if (accept) select   <= code_q;
      if (reject) err_code <= rej_code;
    end
  end

endmodule

// File: tb/tb_expe_cmd_rx.sv
// Directed bench for expe_cmd_rx with a short timeout so timeout corners are reachable.
module tb_expe_cmd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] select;
  logic       sel_update;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  expe_cmd_rx #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .select(select), .sel_update(sel_update), .err(err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [7:0] sel;
    logic       upd;
    logic       er;
    logic [1:0] ec;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] s, input logic u,
                       input logic e, input logic [1:0] ec, input logic b);
    cmp({tag, ".select"},     select,             s);
    cmp({tag, ".sel_update"}, {7'd0, sel_update}, {7'd0, u});
    cmp({tag, ".err"},        {7'd0, err},        {7'd0, e});
    cmp({tag, ".err_code"},   {6'd0, err_code},   {6'd0, ec});
    cmp({tag, ".busy"},       {7'd0, busy},       {7'd0, b});
    cmp({tag, ".upd_err_excl"}, {7'd0, sel_update & err}, 8'd0);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic reset_cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [7:0] s,
                     input logic u, input logic e, input logic [1:0] ec, input logic b);
    vec_t t;
    t.vld = v; t.data = d; t.sel = s; t.upd = u; t.er = e; t.ec = ec; t.bsy = b;
    vecs.push_back(t);
  endtask

  initial begin
    // Expected outputs are those visible just after the edge that samples each byte.
    add(1, 8'hAA, 8'h00, 0, 0, 2'b00, 1);
    add(1, 8'h23, 8'h00, 0, 0, 2'b00, 1);
    add(1, 8'h89, 8'h23, 1, 0, 2'b00, 0);
    add(1, 8'hAA, 8'h23, 0, 0, 2'b00, 1);
    add(1, 8'h23, 8'h23, 0, 0, 2'b00, 1);
    add(1, 8'h88, 8'h23, 0, 1, 2'b10, 0);
    add(0, 8'h00, 8'h23, 0, 0, 2'b10, 0);
    add(1, 8'hAA, 8'h23, 0, 0, 2'b10, 1);
    add(1, 8'h16, 8'h23, 0, 0, 2'b10, 1);
    add(1, 8'hBC, 8'h23, 0, 1, 2'b01, 0);
    add(1, 8'hAA, 8'h23, 0, 0, 2'b01, 1);
    add(1, 8'h00, 8'h23, 0, 0, 2'b01, 1);
    add(1, 8'hAA, 8'h00, 1, 0, 2'b01, 0);
    add(1, 8'h55, 8'h00, 0, 0, 2'b01, 0);
    add(1, 8'hAA, 8'h00, 0, 0, 2'b01, 1);
    add(1, 8'h41, 8'h00, 0, 0, 2'b01, 1);
    add(1, 8'hEB, 8'h41, 1, 0, 2'b01, 0);
    add(1, 8'hAA, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'h41, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'hEB, 8'h41, 1, 0, 2'b01, 0);
    add(1, 8'hAA, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'hAA, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'h00, 8'h41, 0, 1, 2'b01, 0);
    add(1, 8'hAA, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'h15, 8'h41, 0, 0, 2'b01, 1);
    add(1, 8'hBF, 8'h15, 1, 0, 2'b01, 0);
    add(1, 8'hAA, 8'h15, 0, 0, 2'b01, 1);
    add(1, 8'h2A, 8'h15, 0, 0, 2'b01, 1);
    add(1, 8'h80, 8'h15, 0, 1, 2'b01, 0);
    add(1, 8'hAA, 8'h15, 0, 0, 2'b01, 1);
    add(1, 8'h36, 8'h15, 0, 0, 2'b01, 1);
    add(1, 8'h9C, 8'h36, 1, 0, 2'b01, 0);
    add(1, 8'hAA, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'h37, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'h9D, 8'h36, 0, 1, 2'b01, 0);
    add(1, 8'hAA, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'h10, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'hBA, 8'h36, 0, 1, 2'b01, 0);
    add(1, 8'hAA, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'h16, 8'h36, 0, 0, 2'b01, 1);
    add(1, 8'h00, 8'h36, 0, 1, 2'b10, 0);
    add(1, 8'hAA, 8'h36, 0, 0, 2'b10, 1);
    add(1, 8'h46, 8'h36, 0, 0, 2'b10, 1);
    add(1, 8'hEC, 8'h46, 1, 0, 2'b10, 0);

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'h00, 0, 0, 2'b00, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].upd, vecs[i].er, vecs[i].ec, vecs[i].bsy);
    end

    // Timeout while waiting for CODE: 7 quiet cycles still busy, the 8th times out.
    step(1, 8'hAA);
    idle(7);
    check("tmo_code_pre", 8'h46, 0, 0, 2'b10, 1);
    idle(1);
    check("tmo_code", 8'h46, 0, 1, 2'b11, 0);
    idle(1);
    check("tmo_code_after", 8'h46, 0, 0, 2'b11, 0);

    // Byte on the 7th quiet cycle keeps the frame alive.
    step(1, 8'hAA);
    idle(6);
    step(1, 8'h21);
    check("late7_code", 8'h46, 0, 0, 2'b11, 1);
    step(1, 8'h8B);
    check("late7_sum", 8'h21, 1, 0, 2'b11, 0);

    // Byte in the very cycle the counter hits its limit wins over the timeout.
    step(1, 8'hAA);
    idle(7);
    step(1, 8'h31);
    check("late8_code", 8'h21, 0, 0, 2'b11, 1);
    step(1, 8'h9B);
    check("late8_sum", 8'h31, 1, 0, 2'b11, 0);

    // Timeout while waiting for CHK.
    step(1, 8'hAA);
    step(1, 8'h11);
    idle(7);
    check("tmo_sum_pre", 8'h31, 0, 0, 2'b11, 1);
    idle(1);
    check("tmo_sum", 8'h31, 0, 1, 2'b11, 0);

    // Reset mid-frame discards it; a lone checksum byte afterwards is ignored.
    step(1, 8'hAA);
    step(1, 8'h46);
    reset_cycle(0, 8'h00);
    check("rst_mid", 8'h00, 0, 0, 2'b00, 0);
    step(1, 8'hEC);
    check("rst_lone", 8'h00, 0, 0, 2'b00, 0);

    // Reset beats a header strobe in the same cycle.
    reset_cycle(1, 8'hAA);
    check("rst_prio", 8'h00, 0, 0, 2'b00, 0);
    step(1, 8'h23);
    check("rst_prio_b1", 8'h00, 0, 0, 2'b00, 0);
    step(1, 8'h89);
    check("rst_prio_b2", 8'h00, 0, 0, 2'b00, 0);

    step(1, 8'hAA);
    step(1, 8'h12);
    step(1, 8'hB8);
    check("post_rst_frame", 8'h12, 1, 0, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
